hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined RV32I core.
- Keeps a shadow copy of the destination-register information for the E, M and W stages.
- Drives the 2-bit selects of the two E-stage operand forwarding muxes (ForwardAE/ForwardBE), plus the F/D stall and D/E flush controls.
- Provides saturating stall and flush event counters for performance debug.

Parameters:
- CNT_WIDTH, 32, width of the stall_count and flush_count event counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Rs1D  input  5  rs1 field of the instruction in D.
- Rs2D  input  5  rs2 field of the instruction in D.
- RdD  input  5  rd field of the instruction in D.
- RegWriteD  input  1  instruction in D writes the register file.
- LoadD  input  1  instruction in D is a load (ResultSrcD == memory).
- PCSrcE  input  1  taken branch or jump resolved in E.
- ForwardAE  output  2  select for the SrcA forwarding mux: 00 register file, 01 ResultW, 10 ALUResultM (11 is never driven).
- ForwardBE  output  2  select for the SrcB forwarding mux; same encoding as ForwardAE.
- StallF  output  1  hold the PC register.
- StallD  output  1  hold the IF/ID register.
- FlushD  output  1  clear the IF/ID register.
- FlushE  output  1  clear the ID/EX register.
- stall_count  output  CNT_WIDTH  number of cycles with StallD asserted (saturating).
- flush_count  output  CNT_WIDTH  number of cycles with FlushD asserted (saturating).

Behaviour:
- Shadow state (registered): Rs1E, Rs2E, RdE, RegWriteE, LoadE; RdM, RegWriteM; RdW, RegWriteW.
- Reset (synchronous, active-high): all shadow state and both counters go to 0. Consequently every output reads 0 in the cycle after reset is sampled.
- Reset asserted mid-operation discards all in-flight hazard state; no stall or flush persists past reset.
- Each rising edge, when not in reset:
  - M <= E, and W <= M (these stages always advance).
  - If FlushE: E shadow is loaded with a bubble (all fields 0).
  - Otherwise E shadow <= D inputs.
  - StallD never holds the E shadow: a stall inserts a bubble through FlushE.
- lwStall = LoadE & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D). This is combinational from the D inputs and the E shadow.
- Stall and flush outputs (combinational):
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - PCSrcE has priority: the branch target must load the PC, so when PCSrcE is asserted there is no stall.
- ForwardAE (combinational from registered state only, so no D-to-E combinational path):
  - 10 if RegWriteM & (RdM != 0) & (RdM == Rs1E).
  - else 01 if RegWriteW & (RdW != 0) & (RdW == Rs1E).
  - else 00.
  - M has priority over W, giving the newest value.
- ForwardBE: identical rule using Rs2E.
- x0 as destination never triggers forwarding or a stall.
- Load-use latency: exactly one stall cycle. On the following cycle the load is in M, so a W-forward is resolved one cycle later; the M-forward path is never used for a load.
- Counters:
  - Increment by 1 on each clock edge where StallD (resp. FlushD) is 1.
  - Hold at all-ones (no wrap).
  - Both counters increment in the same cycle when both conditions hold.

Test Plan:
- Reset: hold reset for 2 cycles with RegWriteD=1, RdD=5, Rs1D=5 driven. Required: all outputs 0 during and after reset, and both counters 0.
- M forward: cycle0 D: add x5 (RegWriteD=1, RdD=5). Cycle1 D: Rs1D=5, Rs2D=5. Required: in cycle2, ForwardAE=10 and ForwardBE=10.
- W forward and priority:
  - Write x7 (cycle0), then an unrelated write to x8 (cycle1), then a consumer with Rs1D=7 (cycle2). Required: in cycle3, ForwardAE=01.
  - Repeat with x7 written in both cycle0 and cycle1. Required: ForwardAE=10.
- Load-use: D: lw x3 (LoadD=1, RdD=3), next D: Rs2D=3. Required:
  - StallF=StallD=FlushE=1 for exactly one cycle; stall_count=1.
  - The consumer, once in E, sees ForwardBE=01.
- x0 / branch:
  - lw x0 followed by Rs1D=0. Required: no stall, ForwardAE=00.
  - PCSrcE=1 together with lwStall conditions. Required: FlushD=FlushE=1, StallF=StallD=0, flush_count+1.
- Saturation: CNT_WIDTH=2, 5 consecutive load-use stalls. Required: stall_count stays at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and operand forwarding for the 5-stage RV32I
// pipeline. Keeps shadow copies of the E/M/W destination info, resolves
// load-use stalls and taken-branch flushes, and counts stall/flush cycles
// in saturating counters for performance debug.
module hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdD,
    input  logic                 RegWriteD,
    input  logic                 LoadD,
    input  logic                 PCSrcE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // E-stage shadow
    logic [4:0]           r_rs1_e;
    logic [4:0]           r_rs2_e;
    logic [4:0]           r_rd_e;
    logic                 r_regwrite_e;
    logic                 r_load_e;
    // M-stage shadow
    logic [4:0]           r_rd_m;
    logic                 r_regwrite_m;
    // W-stage shadow
    logic [4:0]           r_rd_w;
    logic                 r_regwrite_w;
    // event counters
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic [CNT_WIDTH-1:0] r_flush_count;

    logic                 w_lw_stall;
    logic                 w_stall;
    logic                 w_flush_d;
    logic                 w_flush_e;
    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;

    // Forward select for one source register: M wins over W so the newest
    // value is used; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       we_m,
        input logic [4:0] rd_m,
        input logic       we_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use detection and stall/flush generation; a taken branch overrides
    // the stall so the branch target can load the PC.
    always_comb begin
        w_lw_stall = 1'b0;
        if (r_load_e && r_regwrite_e && (r_rd_e != 5'd0) &&
            ((r_rd_e == Rs1D) || (r_rd_e == Rs2D))) begin
            w_lw_stall = 1'b1;
        end else begin
            w_lw_stall = 1'b0;
        end
        w_stall   = w_lw_stall & ~PCSrcE;
        w_flush_d = PCSrcE;
        w_flush_e = w_lw_stall | PCSrcE;
    end

    // Forwarding selects, driven only from registered shadow state.
    always_comb begin
        w_fwd_a = fwd_sel(r_rs1_e, r_regwrite_m, r_rd_m, r_regwrite_w, r_rd_w);
        w_fwd_b = fwd_sel(r_rs2_e, r_regwrite_m, r_rd_m, r_regwrite_w, r_rd_w);
    end

    // Pipeline shadow: M and W always advance; E takes a bubble on FlushE
    // (stalls are realised as bubbles, E is never held).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs1_e      <= 5'd0;
            r_rs2_e      <= 5'd0;
            r_rd_e       <= 5'd0;
            r_regwrite_e <= 1'b0;
            r_load_e     <= 1'b0;
            r_rd_m       <= 5'd0;
            r_regwrite_m <= 1'b0;
            r_rd_w       <= 5'd0;
            r_regwrite_w <= 1'b0;
        end else begin
            r_rd_m       <= r_rd_e;
            r_regwrite_m <= r_regwrite_e;
            r_rd_w       <= r_rd_m;
            r_regwrite_w <= r_regwrite_m;
            if (w_flush_e) begin
                r_rs1_e      <= 5'd0;
                r_rs2_e      <= 5'd0;
                r_rd_e       <= 5'd0;
                r_regwrite_e <= 1'b0;
                r_load_e     <= 1'b0;
            end else begin
                r_rs1_e      <= Rs1D;
                r_rs2_e      <= Rs2D;
                r_rd_e       <= RdD;
                r_regwrite_e <= RegWriteD;
                r_load_e     <= LoadD;
            end
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= {CNT_WIDTH{1'b0}};
            r_flush_count <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_stall && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end else begin
                r_stall_count <= r_stall_count;
            end
            if (w_flush_d && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign ForwardAE   = w_fwd_a;
    assign ForwardBE   = w_fwd_b;
    assign StallF      = w_stall;
    assign StallD      = w_stall;
    assign FlushD      = w_flush_d;
    assign FlushE      = w_flush_e;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: a 32-bit-counter instance for the
// functional scenarios and a 2-bit-counter instance for saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, LoadD, PCSrcE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] stall_count, flush_count;

    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_StallF, s_StallD, s_FlushD, s_FlushE;
    logic [1:0]  s_stall_count, s_flush_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .StallF(s_StallF),
        .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    // advance one clock, land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive D-stage inputs and let combinational outputs settle
    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we,
                         input logic ld, input logic pc);
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
        RegWriteD = we; LoadD = ld; PCSrcE = pc;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_d(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE} !== 8'h00 ||
                stall_count !== 32'd0 || flush_count !== 32'd0) begin
                $display("FAIL reset_during cyc%0d got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d want all 0",
                         i, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_count, flush_count);
            end else n_pass++;
        end
        reset = 1'b0;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_total++;
        if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE} !== 8'h00 ||
            stall_count !== 32'd0 || flush_count !== 32'd0) begin
            $display("FAIL reset_after got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d want all 0",
                     ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_count, flush_count);
        end else n_pass++;
    endtask

    task automatic test_m_forward();
        do_reset();
        set_d(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
        tick();
        set_d(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);   // consumer
        tick();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10)
            $display("FAIL m_forward got fa=%b fb=%b want fa=10 fb=10", ForwardAE, ForwardBE);
        else n_pass++;
    endtask

    task automatic test_w_forward();
        // x7, unrelated x8, consumer of x7 -> W forward
        do_reset();
        set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (ForwardAE !== 2'b01 || ForwardBE !== 2'b00)
            $display("FAIL w_forward got fa=%b fb=%b want fa=01 fb=00", ForwardAE, ForwardBE);
        else n_pass++;
        // x7 written twice: newest (M) wins
        do_reset();
        set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_d(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (ForwardAE !== 2'b10)
            $display("FAIL m_over_w_priority got fa=%b want 10", ForwardAE);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw x3
        tick();
        set_d(5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);   // consumer rs2=x3
        n_total++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101)
            $display("FAIL load_use_stall got sf,sd,fd,fe=%b want 1101", {StallF, StallD, FlushD, FlushE});
        else n_pass++;
        tick();                                       // consumer held in D
        n_total++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000 || stall_count !== 32'd1)
            $display("FAIL load_use_one_cycle got sf,sd,fd,fe=%b sc=%0d want 0000 sc=1",
                     {StallF, StallD, FlushD, FlushE}, stall_count);
        else n_pass++;
        tick();                                       // consumer in E, lw in W
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00 || stall_count !== 32'd1)
            $display("FAIL load_use_wfwd got fb=%b fa=%b sc=%0d want fb=01 fa=00 sc=1",
                     ForwardBE, ForwardAE, stall_count);
        else n_pass++;
    endtask

    task automatic test_x0_branch();
        do_reset();
        set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
        tick();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);   // consumer rs1=x0
        n_total++;
        if ({StallF, StallD, FlushE} !== 3'b000)
            $display("FAIL x0_no_stall got sf,sd,fe=%b want 000", {StallF, StallD, FlushE});
        else n_pass++;
        tick();
        n_total++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00)
            $display("FAIL x0_no_forward got fa=%b fb=%b want 00 00", ForwardAE, ForwardBE);
        else n_pass++;
        // taken branch with load-use conditions present
        do_reset();
        set_d(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw x3
        tick();
        set_d(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011)
            $display("FAIL branch_priority got sf,sd,fd,fe=%b want 0011", {StallF, StallD, FlushD, FlushE});
        else n_pass++;
        tick();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (flush_count !== 32'd1 || stall_count !== 32'd0)
            $display("FAIL branch_counts got fc=%0d sc=%0d want fc=1 sc=0", flush_count, stall_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_d(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw x3
        tick();
        set_d(5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (StallD !== 1'b1)
            $display("FAIL mid_reset_pre got sd=%b want 1", StallD);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000 || stall_count !== 32'd0)
            $display("FAIL mid_reset_clear got sf,sd,fd,fe=%b sc=%0d want 0000 sc=0",
                     {StallF, StallD, FlushD, FlushE}, stall_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        // lw x3 reading x3: stalls on every other cycle
        set_d(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();          // 3 stalls so far
        n_total++;
        if (s_stall_count !== 2'd3 || stall_count !== 32'd3)
            $display("FAIL sat_reach got s_sc=%0d sc=%0d want 3 3", s_stall_count, stall_count);
        else n_pass++;
        for (int i = 0; i < 4; i++) tick();          // 5 stalls total
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (s_stall_count !== 2'd3 || stall_count !== 32'd5 || s_flush_count !== 2'd0)
            $display("FAIL sat_hold got s_sc=%0d sc=%0d s_fc=%0d want 3 5 0",
                     s_stall_count, stall_count, s_flush_count);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
        RegWriteD = 1'b0; LoadD = 1'b0; PCSrcE = 1'b0;
        test_reset();
        test_m_forward();
        test_w_forward();
        test_load_use();
        test_x0_branch();
        test_reset_mid_op();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
